// File: rtl/idecode_queue.sv
// idecoder: combinational split of a 32-bit instruction into its decoded fields
module idecoder (
  input  logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [6:0]  opcode,
  output logic        en_status,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rm,
  output logic [1:0]  shift_op,
  output logic [4:0]  imm5,
  output logic [11:0] imm12,
  output logic [31:0] imm_branch,
  output logic        P,
  output logic        U,
  output logic        W
);
  assign cond       = instr[31:28];
  assign en_status  = instr[20];
  assign rn         = instr[19:16];
  assign rd         = instr[15:12];
  assign rs         = instr[11:8];
  assign rm         = instr[3:0];
  assign shift_op   = instr[6:5];
  assign imm5       = instr[11:7];
  assign imm12      = instr[11:0];
  assign imm_branch = {{8{instr[23]}}, instr[23:0]};
  assign P          = instr[24];
  assign U          = instr[23];
  assign W          = instr[21];
  // opcode class: halt and hint-NOP are special encodings, then data-processing, load/store, other
  always_comb
    opcode = (instr[27:20] == 8'h10) ? 7'b0000001 :
             (instr[27:23] == 5'b00110 && instr[21:20] == 2'b10) ? 7'b0000000 :
             (instr[27:26] == 2'b00) ? {2'b01, instr[4] & ~instr[25], instr[24:21]} :
             (instr[27:26] == 2'b01) ? {4'b1000, instr[25], instr[22], instr[20]} :
             {3'b110, instr[27:24]};
endmodule

// idecode_queue: buffered instruction decoder with FIFO, bypass, flush and sticky halt
module idecode_queue #(
  parameter int             DEPTH       = 4,
  parameter int             PC_WIDTH    = 32,
  parameter int             BYPASS      = 1,
  parameter logic [6:0]     HALT_OPCODE = 7'b0000001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [3:0]                   out_cond,
  output logic [6:0]                   out_opcode,
  output logic                         out_en_status,
  output logic [3:0]                   out_rn,
  output logic [3:0]                   out_rd,
  output logic [3:0]                   out_rs,
  output logic [3:0]                   out_rm,
  output logic [1:0]                   out_shift_op,
  output logic [4:0]                   out_imm5,
  output logic [11:0]                  out_imm12,
  output logic [31:0]                  out_imm_branch,
  output logic                         out_P,
  output logic                         out_U,
  output logic                         out_W,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [31+PC_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic                 has_head, halt_take, load_en, pop, byp, push, load;
  logic [31:0]          d_instr;
  logic [PC_WIDTH-1:0]  d_pc;
  logic [3:0]           d_cond, d_rn, d_rd, d_rs, d_rm;
  logic [6:0]           d_opcode;
  logic                 d_en_status, d_P, d_U, d_W;
  logic [1:0]           d_shift_op;
  logic [4:0]           d_imm5;
  logic [11:0]          d_imm12;
  logic [31:0]          d_imm_branch;
  // handshake control; a retiring HALT blocks the load behind it in the same cycle
  always_comb begin
    has_head  = count != '0;
    in_ready  = (count < CW'(DEPTH)) && !flush && !halted;
    halt_take = out_valid && out_ready && out_opcode == HALT_OPCODE;
    load_en   = (!out_valid || out_ready) && !halted && !halt_take;
    pop       = load_en && has_head;
    byp       = BYPASS != 0 && load_en && !has_head && in_valid && in_ready;
    push      = in_valid && in_ready && !byp;
    load      = pop || byp;
    {d_instr, d_pc} = has_head ? mem[rd_ptr] : {in_instr, in_pc};
  end
  idecoder u_dec (
    .instr(d_instr), .cond(d_cond), .opcode(d_opcode), .en_status(d_en_status),
    .rn(d_rn), .rd(d_rd), .rs(d_rs), .rm(d_rm), .shift_op(d_shift_op),
    .imm5(d_imm5), .imm12(d_imm12), .imm_branch(d_imm_branch),
    .P(d_P), .U(d_U), .W(d_W)
  );
  // FIFO storage write; contents need no reset since occupancy qualifies them
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_instr, in_pc};
  // pointers, occupancy, output register and halt flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      halted <= 1'b0;
      out_pc <= '0;
      {out_cond, out_opcode, out_en_status, out_rn, out_rd, out_rs, out_rm} <= '0;
      {out_shift_op, out_imm5, out_imm12, out_imm_branch, out_P, out_U, out_W} <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      out_valid <= load || (out_valid && !out_ready);
      halted <= halted || halt_take;
      if (load) begin
        out_pc <= d_pc;
        {out_cond, out_opcode, out_en_status, out_rn, out_rd, out_rs, out_rm} <=
          {d_cond, d_opcode, d_en_status, d_rn, d_rd, d_rs, d_rm};
        {out_shift_op, out_imm5, out_imm12, out_imm_branch, out_P, out_U, out_W} <=
          {d_shift_op, d_imm5, d_imm12, d_imm_branch, d_P, d_U, d_W};
      end
    end
  end
endmodule

// File: tb/tb_idecode_queue.sv
// tb_idecode_queue: random and directed checks of idecode_queue against a queue-based model
module tb_idecode_queue;
  localparam int         D    = 4;
  localparam int         PW   = 32;
  localparam logic [6:0] HALT = 7'b0000001;
  localparam logic [31:0] NOP_I  = 32'h03200000;
  localparam logic [31:0] HALT_I = 32'h01000000;
  localparam logic [31:0] T_I    = 32'h51555555;

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, halted;
  logic [31:0] in_instr = '0;
  logic [PW-1:0] in_pc = '0, out_pc;
  logic [3:0] out_cond, out_rn, out_rd, out_rs, out_rm;
  logic [6:0] out_opcode;
  logic out_en_status, out_P, out_U, out_W;
  logic [1:0] out_shift_op;
  logic [4:0] out_imm5;
  logic [11:0] out_imm12;
  logic [31:0] out_imm_branch;
  logic [$clog2(D+1)-1:0] count;

  idecode_queue #(.DEPTH(D), .PC_WIDTH(PW), .BYPASS(1), .HALT_OPCODE(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_cond(out_cond), .out_opcode(out_opcode), .out_en_status(out_en_status),
    .out_rn(out_rn), .out_rd(out_rd), .out_rs(out_rs), .out_rm(out_rm),
    .out_shift_op(out_shift_op), .out_imm5(out_imm5), .out_imm12(out_imm12),
    .out_imm_branch(out_imm_branch), .out_P(out_P), .out_U(out_U), .out_W(out_W),
    .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cond; logic [6:0] op; logic en; logic [3:0] rn, rd, rs, rm;
    logic [1:0] sh; logic [4:0] i5; logic [11:0] i12; logic [31:0] br; logic p, u, w;
  } dec_t;
  typedef struct packed { logic [31:0] instr; logic [PW-1:0] pc; } ent_t;

  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    d.cond = i[31:28]; d.en = i[20]; d.rn = i[19:16]; d.rd = i[15:12]; d.rs = i[11:8];
    d.rm = i[3:0]; d.sh = i[6:5]; d.i5 = i[11:7]; d.i12 = i[11:0];
    d.br = {{8{i[23]}}, i[23:0]}; d.p = i[24]; d.u = i[23]; d.w = i[21];
    if (i[27:20] == 8'h10) d.op = HALT;
    else if (i[27:23] == 5'b00110 && i[21:20] == 2'b10) d.op = 7'b0;
    else if (i[27:26] == 2'b00) d.op = {2'b01, i[4] & ~i[25], i[24:21]};
    else if (i[27:26] == 2'b01) d.op = {4'b1000, i[25], i[22], i[20]};
    else d.op = {3'b110, i[27:24]};
    return d;
  endfunction

  int ncmp = 0, nerr = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  ent_t q[$];
  ent_t e;
  dec_t mo = '0;
  logic [PW-1:0] mpc = '0;
  bit mv = 0, mh = 0, known = 0, rdy, take, ok;

  // reference model: advances on each rising edge from the inputs it sees there
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); mv = 0; mh = 0; mo = '0; mpc = '0; known = 1;
    end else if (flush) begin
      q.delete(); mv = 0; mh = 0;
    end else begin
      rdy  = q.size() < D && !mh;
      take = mv && out_ready && mo.op == HALT;
      ok   = (!mv || out_ready) && !mh && !take;
      if (ok && q.size() > 0) begin
        e = q.pop_front(); mo = dec(e.instr); mpc = e.pc; mv = 1;
        if (in_valid && rdy) q.push_back({in_instr, in_pc});
      end else if (ok && in_valid && rdy) begin
        mo = dec(in_instr); mpc = in_pc; mv = 1;
      end else begin
        if (in_valid && rdy) q.push_back({in_instr, in_pc});
        if (out_ready) mv = 0;
      end
      if (take) mh = 1;
    end
  end

  // compare DUT against the model midway through every cycle
  always @(negedge clk) if (known) begin
    chk("in_ready", 128'(in_ready), 128'(q.size() < D && !flush && !mh));
    chk("out_valid", 128'(out_valid), 128'(mv));
    chk("count", 128'(count), 128'(q.size()));
    chk("halted", 128'(halted), 128'(mh));
    if (mv) begin
      chk("out_pc", 128'(out_pc), 128'(mpc));
      chk("fields", 128'({out_cond, out_opcode, out_en_status, out_rn, out_rd, out_rs, out_rm,
                          out_shift_op, out_imm5, out_imm12, out_imm_branch, out_P, out_U, out_W}),
          128'(mo));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [PW-1:0] p,
                     input logic ordy, input logic fl, input logic rn);
    in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst_n = rn;
    @(posedge clk); #1;
  endtask

  logic [31:0] ri;
  int r;
  initial begin
    cyc(1, T_I, 32'h10, 1, 1, 0);
    cyc(1, 32'hdeadbeef, 32'h20, 0, 0, 0);
    chk("rst_valid", 128'(out_valid), 0);
    chk("rst_count", 128'(count), 0);
    chk("rst_halted", 128'(halted), 0);
    chk("rst_pc", 128'(out_pc), 0);
    chk("rst_fields", 128'({out_cond, out_opcode, out_en_status, out_rn, out_rd, out_rs, out_rm,
        out_shift_op, out_imm5, out_imm12, out_imm_branch, out_P, out_U, out_W}), 0);
    rst_n = 1; in_valid = 0; flush = 0; out_ready = 0; #1;
    chk("rst_in_ready", 128'(in_ready), 1);
    cyc(1, T_I, 32'h100, 0, 0, 1);
    chk("byp_valid", 128'(out_valid), 1);
    chk("byp_opcode", 128'(out_opcode), 128'(7'b0111010));
    chk("byp_cond", 128'(out_cond), 5);
    chk("byp_regs", 128'({out_rn, out_rd, out_rs, out_rm}), 128'(16'h5555));
    chk("byp_shift", 128'(out_shift_op), 2);
    chk("byp_imm5", 128'(out_imm5), 128'(5'b01010));
    chk("byp_imm12", 128'(out_imm12), 128'(12'h555));
    chk("byp_branch", 128'(out_imm_branch), 128'(32'h00555555));
    chk("byp_pc", 128'(out_pc), 128'(32'h100));
    chk("byp_count", 128'(count), 0);
    cyc(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, NOP_I, 32'h200 + 4 * k, 0, 0, 1);
    chk("full_count", 128'(count), 4);
    chk("full_in_ready", 128'(in_ready), 0);
    chk("full_head_pc", 128'(out_pc), 128'(32'h200));
    for (int k = 1; k < 5; k++) begin
      cyc(0, 0, 0, 1, 0, 1);
      chk("drain_pc", 128'(out_pc), 128'(32'h200 + 4 * k));
      chk("drain_opcode", 128'(out_opcode), 0);
    end
    cyc(0, 0, 0, 1, 0, 1);
    chk("drain_empty", 128'(out_valid), 0);
    cyc(1, NOP_I, 32'h300, 0, 0, 1);
    cyc(1, HALT_I, 32'h304, 0, 0, 1);
    cyc(1, NOP_I, 32'h308, 0, 0, 1);
    chk("halt_q_count", 128'(count), 2);
    cyc(0, 0, 0, 1, 0, 1);
    chk("halt_opcode", 128'(out_opcode), 128'(7'b0000001));
    chk("halt_pc", 128'(out_pc), 128'(32'h304));
    cyc(0, 0, 0, 1, 0, 1);
    chk("halted", 128'(halted), 1);
    chk("halted_valid", 128'(out_valid), 0);
    chk("halted_count", 128'(count), 1);
    chk("halted_in_ready", 128'(in_ready), 0);
    cyc(1, NOP_I, 32'h310, 1, 0, 1);
    chk("halted_keep", 128'(count), 1);
    cyc(1, T_I, 32'h400, 1, 1, 1);
    chk("flush_halted", 128'(halted), 0);
    chk("flush_count", 128'(count), 0);
    for (int k = 0; k < 4; k++) cyc(1, NOP_I, 32'h500 + 4 * k, 0, 0, 1);
    chk("pre_flush_count", 128'(count), 3);
    cyc(1, T_I, 32'h600, 0, 1, 1);
    chk("flush_count2", 128'(count), 0);
    chk("flush_valid", 128'(out_valid), 0);
    cyc(1, T_I, 32'h700, 1, 0, 1);
    chk("post_flush_byp", 128'({out_valid, out_pc}), 128'({1'b1, 32'h700}));
    for (int k = 0; k < 3; k++) cyc(1, NOP_I, 32'h800 + 4 * k, 0, 0, 1);
    cyc(1, NOP_I, 32'h80c, 0, 1, 0);
    chk("fr_count", 128'(count), 0);
    chk("fr_pc", 128'(out_pc), 0);
    for (int k = 0; k < 3; k++) cyc(1, NOP_I, 32'h900 + 4 * k, 0, 0, 1);
    for (int k = 3; k < 13; k++) begin
      cyc(1, NOP_I, 32'h900 + 4 * k, 1, 0, 1);
      chk("steady_count", 128'(count), 2);
      chk("steady_pc", 128'(out_pc), 128'(32'h900 + 4 * (k - 2)));
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(15);
      ri = r < 1 ? HALT_I : r < 4 ? NOP_I : $urandom;
      cyc($urandom_range(3) != 0, ri, $urandom, $urandom_range(3) != 0,
          $urandom_range(49) == 0, $urandom_range(149) != 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
